seq_loader: RTL and testbench

Upstream loading stage for the Needleman-Wunsch datapath. It accepts a byte stream of nucleotide characters over a valid/ready handshake, encodes each character into the 3-bit symbol format, and drives the sequence RAM write port (`din_ram`, `en_ram`, `weA`, `weB`, `addr_dinA`, `addr_dinB`) to fill sequence A and then sequence B. When both sequences are stored it reports their lengths and raises `load_done`, which the control FSM uses to start matrix initialisation.

---
 rtl/nw_pkg.sv | 18 +
 rtl/sym_encoder.sv | 35 +++
 rtl/seq_loader.sv | 133 +++++++++++++
 tb/tb_seq_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: symbol codes, stream terminators, loader states.
package nw_pkg;
    localparam logic [2:0] SYM_A = 3'd1;
    localparam logic [2:0] SYM_C = 3'd2;
    localparam logic [2:0] SYM_G = 3'd3;
    localparam logic [2:0] SYM_T = 3'd4;

    localparam logic [7:0] CHR_SEP = 8'h3B;
    localparam logic [7:0] CHR_EOL = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_DONE,
        ST_ERR
    } loader_state_e;
endpackage

// File: rtl/sym_encoder.sv
// Combinational ASCII-to-symbol encoder with character class flags.
// SEQ_LOADER_LOWERCASE_EN: also accept a/c/g/t as their uppercase forms.
module sym_encoder
    import nw_pkg::*;
(
    input  logic [7:0] char_in,
    output logic [2:0] sym,
    output logic       is_sym,
    output logic       is_sep,
    output logic       is_eol,
    output logic       is_illegal
);
    logic [7:0] ch_up;

    always_comb begin
`ifdef SEQ_LOADER_LOWERCASE_EN
        // Folding to uppercase is safe: only the four letters survive the case below.
        ch_up = (char_in >= 8'h61 && char_in <= 8'h7A) ? (char_in & 8'hDF) : char_in;
`else
        ch_up = char_in;
`endif
        sym = 3'd0;
        case (ch_up)
            8'h41:   sym = SYM_A;
            8'h43:   sym = SYM_C;
            8'h47:   sym = SYM_G;
            8'h54:   sym = SYM_T;
            default: sym = 3'd0;
        endcase
        is_sym     = (sym != 3'd0);
        is_sep     = (char_in == CHR_SEP);
        is_eol     = (char_in == CHR_EOL);
        is_illegal = !(is_sym || is_sep || is_eol);
    end
endmodule

// File: rtl/seq_loader.sv
// Loads sequence A (';'-terminated) then B ('\n'-terminated) into the sequence RAMs.
// Lowercase input is accepted when SEQ_LOADER_LOWERCASE_EN is defined (see sym_encoder).
module seq_loader
    import nw_pkg::*;
#(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic [2:0]       din_ram,
    output logic             en_ram,
    output logic             weA,
    output logic             weB,
    output logic [BitAddr:0] addr_dinA,
    output logic [BitAddr:0] addr_dinB,
    output logic [BitAddr:0] len_a,
    output logic [BitAddr:0] len_b,
    output logic             load_done,
    output logic             load_err
);
    localparam logic [BitAddr:0] LEN_MAX = (BitAddr + 1)'(N);
    localparam logic [BitAddr:0] LEN_ONE = (BitAddr + 1)'(1);

    loader_state_e    state_q;
    logic [2:0]       din_q;
    logic             en_q, we_a_q, we_b_q;
    logic [BitAddr:0] addr_a_q, addr_b_q, len_a_q, len_b_q;
    logic             done_q, err_q;

    logic [2:0] sym;
    logic       is_sym, is_sep, is_eol, is_illegal;

    sym_encoder u_enc (
        .char_in    (char_in),
        .sym        (sym),
        .is_sym     (is_sym),
        .is_sep     (is_sep),
        .is_eol     (is_eol),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            din_q    <= '0;
            en_q     <= 1'b0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            len_a_q  <= '0;
            len_b_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            we_a_q <= 1'b0;
            we_b_q <= 1'b0;
            case (state_q)
                ST_LOAD_A: begin
                    if (char_valid) begin
                        if (is_sym) begin
                            if (len_a_q == LEN_MAX) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                len_a_q  <= len_a_q + LEN_ONE;
                                addr_a_q <= len_a_q + LEN_ONE;
                                din_q    <= sym;
                                en_q     <= 1'b1;
                                we_a_q   <= 1'b1;
                            end
                        end else if (is_illegal || is_eol || len_a_q == '0) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD_B;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (char_valid) begin
                        if (is_sym) begin
                            if (len_b_q == LEN_MAX) begin
                                state_q <= ST_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                len_b_q  <= len_b_q + LEN_ONE;
                                addr_b_q <= len_b_q + LEN_ONE;
                                din_q    <= sym;
                                en_q     <= 1'b1;
                                we_b_q   <= 1'b1;
                            end
                        end else if (is_illegal || is_sep || len_b_q == '0) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all restart the same way.
                    if (start) begin
                        state_q <= ST_LOAD_A;
                        len_a_q <= '0;
                        len_b_q <= '0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign char_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign din_ram    = din_q;
    assign en_ram     = en_q;
    assign weA        = we_a_q;
    assign weB        = we_b_q;
    assign addr_dinA  = addr_a_q;
    assign addr_dinB  = addr_b_q;
    assign len_a      = len_a_q;
    assign len_b      = len_b_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
endmodule

// File: tb/tb_seq_loader.sv
// Self-checking bench for seq_loader: directed scenarios plus random strings against a character-level model.
module tb_seq_loader;
    localparam int N  = 4;
    localparam int BA = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    char_in = 8'h00;
    logic          char_valid = 1'b0;
    logic          char_ready;
    logic [2:0]    din_ram;
    logic          en_ram, weA, weB;
    logic [BA:0]   addr_dinA, addr_dinB, len_a, len_b;
    logic          load_done, load_err;

    seq_loader #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .din_ram    (din_ram),
        .en_ram     (en_ram),
        .weA        (weA),
        .weB        (weB),
        .addr_dinA  (addr_dinA),
        .addr_dinB  (addr_dinB),
        .len_a      (len_a),
        .len_b      (len_b),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 idle, 1 loading A, 2 loading B, 3 done, 4 error.
    int m_ph = 0;
    int m_len[2];
    int m_addr[2];
    bit m_wr, m_acc, m_rst;
    int m_wseq, m_wsym;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int enc(input logic [7:0] c);
        logic [7:0] u;
        u = c;
`ifdef SEQ_LOADER_LOWERCASE_EN
        if (c >= 8'h61 && c <= 8'h7A) u = c - 8'd32;
`endif
        case (u)
            8'h41:   return 1;
            8'h43:   return 2;
            8'h47:   return 3;
            8'h54:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic void model_char(input logic [7:0] c);
        int s, sym;
        s   = m_ph - 1;
        sym = enc(c);
        if (sym != 0) begin
            if (m_len[s] == N) m_ph = 4;
            else begin
                m_len[s]++;
                m_addr[s] = m_len[s];
                m_wr   = 1;
                m_wseq = s;
                m_wsym = sym;
            end
        end else if (c == ((s == 0) ? 8'h3B : 8'h0A) && m_len[s] != 0) begin
            m_ph = m_ph + 1;
        end else begin
            m_ph = 4;
        end
    endfunction

    task automatic step();
        m_acc = 0;
        m_wr  = 0;
        m_rst = !rst;
        if (!rst) begin
            m_ph = 0;
            m_len[0] = 0; m_len[1] = 0;
            m_addr[0] = 0; m_addr[1] = 0;
        end else if ((m_ph == 0 || m_ph == 3 || m_ph == 4) && start) begin
            m_ph = 1;
            m_len[0] = 0; m_len[1] = 0;
        end else if ((m_ph == 1 || m_ph == 2) && char_valid) begin
            m_acc = 1;
            model_char(char_in);
        end
        @(posedge clk);
        #1;
        if (m_acc)
            $display("xfer ch=%02h ph=%0d wr=%0d lenA=%0d lenB=%0d", char_in, m_ph, m_wr, m_len[0], m_len[1]);
        check("char_ready", 32'(char_ready), 32'(m_ph == 1 || m_ph == 2));
        check("en_ram", 32'(en_ram), 32'(m_wr));
        check("weA", 32'(weA), 32'(m_wr && m_wseq == 0));
        check("weB", 32'(weB), 32'(m_wr && m_wseq == 1));
        if (m_wr) check("din_ram", 32'(din_ram), 32'(m_wsym));
        if (m_rst) check("din_rst", 32'(din_ram), 32'd0);
        check("addr_dinA", 32'(addr_dinA), 32'(m_addr[0]));
        check("addr_dinB", 32'(addr_dinB), 32'(m_addr[1]));
        check("len_a", 32'(len_a), 32'(m_len[0]));
        check("len_b", 32'(len_b), 32'(m_len[1]));
        check("load_done", 32'(load_done), 32'(m_ph == 3));
        check("load_err", 32'(load_err), 32'(m_ph == 4));
    endtask

    // bp: 0 valid held high, 1 valid every other cycle, 2 random valid plus stray start pulses.
    task automatic load(input string s, input int bp);
        int i, cyc, bound;
        i = 0; cyc = 0; bound = 4 * s.len() + 8;
        char_valid = 0;
        start = 1;
        step();
        start = 0;
        while (i < s.len() && (m_ph == 1 || m_ph == 2) && cyc < bound) begin
            char_in    = s[i];
            char_valid = (bp == 0) ? 1'b1 : (bp == 1) ? (cyc % 2 == 0) : ($urandom_range(1) == 1);
            start      = (bp == 2) && ($urandom_range(7) == 0);
            step();
            if (m_acc) i++;
            cyc++;
        end
        char_valid = 0;
        start = 0;
        if (cyc >= bound) check("load_timeout", 32'(cyc), 32'(bound - 1));
        step();
        step();
    endtask

    function automatic string rand_str();
        string s, t;
        int na, nb, k;
        string pool;
        pool = "ACGT";
        s = "";
        t = " ";
        na = $urandom_range(0, N + 1);
        nb = $urandom_range(0, N + 1);
        for (int j = 0; j < na + nb + 2; j++) begin
            k = $urandom_range(0, 19);
            if (j == na) t[0] = 8'h3B;
            else if (j == na + nb + 1) t[0] = 8'h0A;
            else if (k == 0) t[0] = 8'h58;
            else if (k == 1) t[0] = 8'h61;
            else if (k == 2) t[0] = (j < na) ? 8'h0A : 8'h3B;
            else t[0] = pool[$urandom_range(0, 3)];
            s = {s, t};
        end
        return s;
    endfunction

    initial begin
        rst = 0;
        step();
        step();
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_done", 32'(load_done | load_err), 32'd0);
        rst = 1;
        step();

        load("ACGT;GA\n", 0);
        check("t1_len_a", 32'(len_a), 32'd4);
        check("t1_len_b", 32'(len_b), 32'd2);
        check("t1_done", 32'(load_done), 32'd1);

        load(";", 0);
        check("t2_err", 32'(load_err), 32'd1);
        load("AX", 0);
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_len_a", 32'(len_a), 32'd1);

        load("ACGTA", 0);
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_addrA", 32'(addr_dinA), 32'd4);

        load("AC;T\n", 1);
        check("t5_len_a", 32'(len_a), 32'd2);
        check("t5_len_b", 32'(len_b), 32'd1);
        check("t5_done", 32'(load_done), 32'd1);

        load("AC", 0);
        rst = 0;
        step();
        check("t6_all_zero", 32'({char_ready, din_ram, en_ram, weA, weB, addr_dinA, addr_dinB,
                                  len_a, len_b, load_done, load_err}), 32'd0);
        rst = 1;
        load("G;C\n", 0);
        check("t6_len_a", 32'(len_a), 32'd1);
        check("t6_len_b", 32'(len_b), 32'd1);

        load("acg;t\n", 0);
`ifdef SEQ_LOADER_LOWERCASE_EN
        check("t7_done", 32'(load_done), 32'd1);
`else
        check("t7_err", 32'(load_err), 32'd1);
        check("t7_len_a", 32'(len_a), 32'd0);
`endif

        for (int r = 0; r < 40; r++) load(rand_str(), $urandom_range(0, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
